// File: rtl/rcb_mc.sv
// rcb_mc: round-robin multi-channel read / host write arbiter around one single-port BRAM.
// Define RCB_MC_PARITY_EN for per-byte even parity storage and the rd_perr output.
module rcb_mc #(
  parameter int NUM_RD = 2,
  parameter int DATA_W = 64,
  parameter int ADDR_W = 14,
  parameter int MAX_WR_STALL = 16,
  localparam int CH_W = NUM_RD > 1 ? $clog2(NUM_RD) : 1,
  localparam int BE_W = DATA_W / 8
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [NUM_RD-1:0]        rd_req,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD-1:0]        rd_gnt,
  output logic                     rd_vld,
  output logic [CH_W-1:0]          rd_ch,
  output logic [DATA_W-1:0]        rd_data,
  input  logic                     wr_req,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic [BE_W-1:0]          wr_be,
  output logic                     wr_gnt,
  output logic                     wr_done,
  output logic [15:0]              wr_force_cnt
`ifdef RCB_MC_PARITY_EN
  ,
  output logic                     rd_perr
`endif
);
  localparam int ST_W = MAX_WR_STALL > 0 ? $clog2(MAX_WR_STALL + 1) : 1;
  if (NUM_RD < 1 || NUM_RD > 8) begin : g_bad_num_rd
    $error("rcb_mc: NUM_RD must be in 1..8");
  end
  if (DATA_W % 8 != 0) begin : g_bad_data_w
    $error("rcb_mc: DATA_W must be a multiple of 8");
  end
  logic [CH_W-1:0]   rr_ptr, sel;
  logic [NUM_RD-1:0] rot;
  logic              hit, force_wr, rd_go;
  logic [ST_W-1:0]   stall;
  logic              p_vld, p_we;
  logic [CH_W-1:0]   p_ch;
  logic [ADDR_W-1:0] p_addr;
  logic [DATA_W-1:0] p_data;
  logic [BE_W-1:0]   p_be;
  logic [DATA_W-1:0] mem [2**ADDR_W];
  assign force_wr = wr_req && stall == ST_W'(MAX_WR_STALL);
  // requests rotated so that bit 0 is the channel at rr_ptr
  assign rot = NUM_RD'({rd_req, rd_req} >> rr_ptr);
  always_comb begin
    hit = 1'b0;
    sel = '0;
    for (int k = NUM_RD - 1; k >= 0; k--)
      if (rot[k]) begin
        hit = 1'b1;
        sel = CH_W'((int'(rr_ptr) + k) % NUM_RD);
      end
  end
  assign rd_gnt  = (hit && !force_wr) ? (NUM_RD'(1) << sel) : '0;
  assign rd_go   = |rd_gnt;
  assign wr_gnt  = wr_req && (force_wr || !(|rd_req));
  assign wr_done = p_vld && p_we;
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rr_ptr       <= '0;
      stall        <= '0;
      wr_force_cnt <= '0;
      p_vld        <= 1'b0;
      p_we         <= 1'b0;
      rd_vld       <= 1'b0;
      rd_ch        <= '0;
      rd_data      <= '0;
    end else begin
      p_vld  <= rd_go || wr_gnt;
      p_we   <= wr_gnt;
      stall  <= (wr_req && !wr_gnt) ? stall + 1'b1 : '0;
      rd_vld <= p_vld && !p_we;
      if (rd_go)
        rr_ptr <= CH_W'((int'(sel) + 1) % NUM_RD);
      if (force_wr && |rd_req && wr_force_cnt != 16'hFFFF)
        wr_force_cnt <= wr_force_cnt + 1'b1;
      if (p_vld && !p_we) begin
        rd_ch   <= p_ch;
        rd_data <= mem[p_addr];
      end
    end
  end
  always_ff @(posedge clk) begin
    p_ch   <= sel;
    p_addr <= wr_gnt ? wr_addr : rd_addr[sel*ADDR_W +: ADDR_W];
    p_data <= wr_data;
    p_be   <= wr_be;
  end
  always_ff @(posedge clk)
    if (reset_n && p_vld && p_we)
      for (int k = 0; k < BE_W; k++)
        if (p_be[k])
          mem[p_addr][k*8 +: 8] <= p_data[k*8 +: 8];
`ifdef RCB_MC_PARITY_EN
  logic [BE_W-1:0] pmem [2**ADDR_W];
  function automatic logic [BE_W-1:0] lane_par(input logic [DATA_W-1:0] d);
    for (int k = 0; k < BE_W; k++)
      lane_par[k] = ^d[k*8 +: 8];
  endfunction
  always_ff @(posedge clk)
    if (reset_n && p_vld && p_we)
      for (int k = 0; k < BE_W; k++)
        if (p_be[k])
          pmem[p_addr][k] <= ^p_data[k*8 +: 8];
  always_ff @(posedge clk)
    if (!reset_n)
      rd_perr <= 1'b0;
    else
      rd_perr <= p_vld && !p_we && (lane_par(mem[p_addr]) != pmem[p_addr]);
`endif
endmodule

// File: doc/rcb_mc.md
Name: rcb_mc

Overview:
Multi-channel successor to the strategy RAM control block. It arbitrates one inferred single-port BRAM between NUM_RD symbol-lookup read channels and one host write channel. Reads use round-robin arbitration. Write starvation is bounded by a programmable stall limit. Read data returns on one shared, tagged, registered bus and sits between the feed decoders and the strategy comparators.

Parameters:
NUM_RD, 2, number of read channels (1..8)
DATA_W, 64, RAM word width; must be a multiple of 8
ADDR_W, 14, address width; RAM depth = 2**ADDR_W
MAX_WR_STALL, 16, cycles a pending write may be blocked before it is forced; 0 = write always has top priority

Ports:
clk  in  1  core clock
reset_n  in  1  reset, synchronous, active-low
rd_req  in  NUM_RD  per-channel read request (valid)
rd_addr  in  NUM_RD*ADDR_W  per-channel read address; channel i at [i*ADDR_W +: ADDR_W]
rd_gnt  out  NUM_RD  per-channel grant (ready), combinational, one-hot or zero
rd_vld  out  1  read data valid
rd_ch  out  max(1,$clog2(NUM_RD))  channel tag for rd_data
rd_data  out  DATA_W  registered read data
wr_req  in  1  host write request (valid)
wr_addr  in  ADDR_W  write address
wr_data  in  DATA_W  write data
wr_be  in  DATA_W/8  byte enables
wr_gnt  out  1  write grant (ready), combinational
wr_done  out  1  one-cycle pulse when the write commits
wr_force_cnt  out  16  saturating count of forced writes

Behaviour:
- Transfer rule: a read on channel i happens when rd_req[i] && rd_gnt[i]. A write happens when wr_req && wr_gnt. Requesters hold address and data stable until granted.
- At most one grant per cycle across all channels and the write.
- Priority order, highest first:
  - forced write
  - reads, round-robin
  - unforced write (only when no rd_req is asserted)
- Round-robin search starts at rr_ptr. After a read grant on channel i, rr_ptr becomes (i+1) mod NUM_RD. rr_ptr resets to 0.
- Stall counter (width $clog2(MAX_WR_STALL+1)):
  - increments each cycle wr_req=1 and wr_gnt=0
  - clears on a write grant or when wr_req=0
  - when it equals MAX_WR_STALL, the write is forced on that cycle and all rd_gnt are 0
  - MAX_WR_STALL=0 means any wr_req is granted immediately
- wr_force_cnt increments on every forced grant that had at least one rd_req pending in the same cycle. It saturates at 16'hFFFF.
- Pipeline: the granted operation (addr, we, be, data, ch) is registered at the end of cycle T. The RAM access executes at the end of T+1. A read's rd_data is registered at the end of T+1.
- Latency:
  - read granted in cycle T: rd_vld=1 with rd_ch and rd_data in cycle T+2
  - write granted in cycle T: wr_done=1 in cycle T+1, and the RAM word is updated at the end of T+1
- Byte lane k is written only when wr_be[k]=1; other lanes retain their value.
- Read-after-write: a read of the same address granted in any cycle after the write grant returns the new data. No hazard logic is needed, because the RAM is accessed in grant order.
- Back-to-back operations are allowed every cycle. Throughput is one operation per cycle.
- Reset values:
  - rd_vld=0, rd_ch=0, rd_data=0
  - wr_done=0, wr_force_cnt=0
  - rr_ptr=0, stall counter=0, pipeline valid bits cleared
- Reset mid-operation: in-flight operations are dropped (no rd_vld, no wr_done). RAM contents are not cleared.
- rd_data holds its last value when rd_vld=0.
- Out-of-range NUM_RD or a DATA_W that is not a multiple of 8 triggers $error at elaboration.

Optional Feature:
Macro RCB_MC_PARITY_EN.
- Defined:
  - each RAM word is widened by DATA_W/8 even-parity bits, one per byte
  - each parity bit is written together with its byte lane
  - on read, parity is recomputed; the extra output rd_perr (1 bit) is asserted alongside rd_vld when any byte mismatches
  - rd_perr resets to 0
- Undefined: no parity storage, and no rd_perr port.

Test Plan:
- Reset, then write addr 14'h0010, data 64'hDEAD_BEEF_0123_4567, be 8'hFF. Then read ch0 addr 14'h0010 -> wr_done one cycle after wr_gnt; rd_vld=1, rd_ch=0, rd_data=64'hDEAD_BEEF_0123_4567 two cycles after rd_gnt.
- Write be 8'h0F data 64'hFFFF_FFFF_FFFF_FFFF over the previous word, then read -> 64'hDEAD_BEEF_FFFF_FFFF.
- Hold rd_req=2'b11 continuously for 8 cycles with addresses 5 and 9 -> grants alternate ch0, ch1, ch0, and so on; rd_ch sequence 0,1,0,1 with matching data; no gaps.
- Hold rd_req=2'b11 continuously plus wr_req, MAX_WR_STALL=16 -> wr_gnt in exactly the 17th cycle of wr_req; all rd_gnt=0 that cycle; wr_force_cnt=1.
- Grant a write to addr 7 in cycle T and a read of addr 7 in T+1 -> the read returns the new data.
- Assert reset_n=0 for one cycle one cycle after a read grant -> no rd_vld; after reset, a read of the old address returns the preserved RAM data.
